// File: rtl/execute_stage_if.sv
// execute_stage_if: ID/EX operand bundle, forwarding taps and EX results
// exchanged between the decode/execute pipeline register and the EX stage.
// master = upstream driver, slave = execute stage.
interface execute_stage_if #(
  parameter int XLEN = 32
);
  logic            flush;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] readData1;
  logic [XLEN-1:0] readData2;
  logic [XLEN-1:0] immediateValue;
  logic [2:0]      func3;
  logic [6:0]      func7;
  logic [1:0]      aluSrc1;
  logic [1:0]      aluSrc2;
  logic [2:0]      aluOperation;
  logic            pcUpdate;
  logic            pcAdderSrc;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [4:0]      exMemRd;
  logic [4:0]      memWbRd;
  logic            exMemRegWrite;
  logic            memWbRegWrite;
  logic [XLEN-1:0] exMemData;
  logic [XLEN-1:0] memWbData;
  logic [XLEN-1:0] aluResult;
  logic [XLEN-1:0] storeData;
  logic            branchTaken;
  logic [XLEN-1:0] branchTarget;
  logic            stall;

  modport master (
    output flush, pc, readData1, readData2, immediateValue, func3, func7,
           aluSrc1, aluSrc2, aluOperation, pcUpdate, pcAdderSrc, rs1, rs2,
           exMemRd, memWbRd, exMemRegWrite, memWbRegWrite, exMemData, memWbData,
    input  aluResult, storeData, branchTaken, branchTarget, stall
  );

  modport slave (
    input  flush, pc, readData1, readData2, immediateValue, func3, func7,
           aluSrc1, aluSrc2, aluOperation, pcUpdate, pcAdderSrc, rs1, rs2,
           exMemRd, memWbRd, exMemRegWrite, memWbRegWrite, exMemData, memWbData,
    output aluResult, storeData, branchTaken, branchTarget, stall
  );
endinterface

// File: rtl/execute_stage.sv
// execute_stage: RV32I EX stage. Combinational forwarding, ALU, branch and
// jump resolution. With RV32M_EN defined, an iterative multiply/divide unit
// (IDLE/BUSY/DONE) is built and stalls upstream while busy; without it an
// M-op returns 0 in a single cycle and stall is tied low.
module execute_stage #(
  parameter int XLEN        = 32,
  parameter int MULDIV_ITER = 32
) (
  input logic            clock,
  input logic            reset,
  execute_stage_if.slave bus
);

  // MEM beats WB; x0 is never forwarded.
  function automatic logic [XLEN-1:0] fwd_sel(
    input logic [4:0] rs, input logic [XLEN-1:0] rf_data,
    input logic mem_we, input logic [4:0] mem_rd, input logic [XLEN-1:0] mem_data,
    input logic wb_we, input logic [4:0] wb_rd, input logic [XLEN-1:0] wb_data);
    if (mem_we && (mem_rd != 5'd0) && (mem_rd == rs)) fwd_sel = mem_data;
    else if (wb_we && (wb_rd != 5'd0) && (wb_rd == rs)) fwd_sel = wb_data;
    else fwd_sel = rf_data;
  endfunction

  function automatic logic [XLEN-1:0] alu_fn(
    input logic [2:0] f3, input logic alt, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    logic [4:0] sh;
    sh = b[4:0];
    case (f3)
      3'b000:  alu_fn = alt ? (a - b) : (a + b);
      3'b001:  alu_fn = a << sh;
      3'b010:  alu_fn = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      3'b011:  alu_fn = {{(XLEN-1){1'b0}}, (a < b)};
      3'b100:  alu_fn = a ^ b;
      3'b101: begin
        // Kept as separate arms so the signed shift is not widened to unsigned.
        if (alt) alu_fn = $signed(a) >>> sh;
        else     alu_fn = a >> sh;
      end
      3'b110:  alu_fn = a | b;
      3'b111:  alu_fn = a & b;
      default: alu_fn = {XLEN{1'b0}};
    endcase
  endfunction

  function automatic logic br_cmp(
    input logic [2:0] f3, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    case (f3)
      3'b000:  br_cmp = (a == b);
      3'b001:  br_cmp = (a != b);
      3'b100:  br_cmp = ($signed(a) <  $signed(b));
      3'b101:  br_cmp = ($signed(a) >= $signed(b));
      3'b110:  br_cmp = (a <  b);
      3'b111:  br_cmp = (a >= b);
      default: br_cmp = 1'b0;
    endcase
  endfunction

  logic [XLEN-1:0] fwd1_s, fwd2_s, op1_s, op2_s, alu_s, md_out_s;
  logic [XLEN-1:0] tgt_base_s, tgt_sum_s;
  logic            mop_s, br_s, stall_s;

  assign fwd1_s = fwd_sel(bus.rs1, bus.readData1, bus.exMemRegWrite, bus.exMemRd, bus.exMemData,
                          bus.memWbRegWrite, bus.memWbRd, bus.memWbData);
  assign fwd2_s = fwd_sel(bus.rs2, bus.readData2, bus.exMemRegWrite, bus.exMemRd, bus.exMemData,
                          bus.memWbRegWrite, bus.memWbRd, bus.memWbData);
  assign mop_s  = (bus.aluOperation == 3'b010) && (bus.func7 == 7'b0000001);

  // ALU operand selection.
  always_comb begin
    case (bus.aluSrc1)
      2'b00:   op1_s = fwd1_s;
      2'b01:   op1_s = bus.pc;
      default: op1_s = {XLEN{1'b0}};
    endcase
    case (bus.aluSrc2)
      2'b00:   op2_s = fwd2_s;
      2'b01:   op2_s = bus.immediateValue;
      2'b10:   op2_s = {{(XLEN-3){1'b0}}, 3'b100};
      default: op2_s = {XLEN{1'b0}};
    endcase
  end

  // Result select; I-type only honours func7[5] on right shifts (srai).
  always_comb begin
    case (bus.aluOperation)
      3'b000: alu_s = op1_s + op2_s;
      3'b001: alu_s = {XLEN{1'b0}};
      3'b010: begin
        if (mop_s) alu_s = md_out_s;
        else       alu_s = alu_fn(bus.func3, bus.func7[5], op1_s, op2_s);
      end
      3'b011:  alu_s = alu_fn(bus.func3, bus.func7[5] && (bus.func3 == 3'b101), op1_s, op2_s);
      3'b100:  alu_s = bus.immediateValue;
      default: alu_s = {XLEN{1'b0}};
    endcase
  end

  // Branch decision and redirect target (JALR clears bit 0).
  always_comb begin
    if (bus.aluOperation == 3'b001) br_s = br_cmp(bus.func3, fwd1_s, fwd2_s);
    else                            br_s = bus.pcUpdate;
    tgt_base_s = bus.pcAdderSrc ? fwd1_s : bus.pc;
    tgt_sum_s  = tgt_base_s + bus.immediateValue;
  end

  assign bus.aluResult    = alu_s;
  assign bus.storeData    = fwd2_s;
  assign bus.branchTaken  = br_s & ~stall_s;
  assign bus.branchTarget = bus.pcAdderSrc ? {tgt_sum_s[XLEN-1:1], 1'b0} : tgt_sum_s;
  assign bus.stall        = stall_s;

`ifdef RV32M_EN
  localparam int CW = $clog2(MULDIV_ITER + 1);
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]        state_r;
  logic [CW-1:0]     cnt_r;
  logic [2:0]        f3_r;
  logic [XLEN-1:0]   opb_r, dvd_r;
  logic [2*XLEN-1:0] acc_r, acc_nxt_s, prod_s;
  logic              neg_res_r, neg_rem_r, dvz_r;
  logic              a_sgn_s, b_sgn_s;
  logic [XLEN-1:0]   a_mag_s, b_mag_s, quo_s, rem_s, md_res_s;
  logic [XLEN:0]     mul_sum_s, div_sh_s, div_diff_s;

  // Operand signedness and magnitudes at issue; sign is reapplied at DONE.
  always_comb begin
    a_sgn_s = ((bus.func3 == 3'b001) || (bus.func3 == 3'b010) ||
               (bus.func3 == 3'b100) || (bus.func3 == 3'b110)) && fwd1_s[XLEN-1];
    b_sgn_s = ((bus.func3 == 3'b001) || (bus.func3 == 3'b100) ||
               (bus.func3 == 3'b110)) && fwd2_s[XLEN-1];
    a_mag_s = a_sgn_s ? (-fwd1_s) : fwd1_s;
    b_mag_s = b_sgn_s ? (-fwd2_s) : fwd2_s;
  end

  // One iteration: acc holds {hi,lo} product or {remainder,quotient}.
  always_comb begin
    mul_sum_s  = {1'b0, acc_r[2*XLEN-1:XLEN]} + (acc_r[0] ? {1'b0, opb_r} : {(XLEN+1){1'b0}});
    div_sh_s   = acc_r[2*XLEN-1:XLEN-1];
    div_diff_s = div_sh_s - {1'b0, opb_r};
    if (f3_r[2]) begin
      if (!div_diff_s[XLEN]) acc_nxt_s = {div_diff_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b1};
      else                   acc_nxt_s = {div_sh_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b0};
    end else begin
      acc_nxt_s = {mul_sum_s, acc_r[XLEN-1:1]};
    end
  end

  // Sign fix-up and divide-by-zero override of the latched result.
  always_comb begin
    prod_s = neg_res_r ? (-acc_r) : acc_r;
    quo_s  = acc_r[XLEN-1:0];
    rem_s  = acc_r[2*XLEN-1:XLEN];
    case (f3_r)
      3'b000:          md_res_s = prod_s[XLEN-1:0];
      3'b001, 3'b010,
      3'b011:          md_res_s = prod_s[2*XLEN-1:XLEN];
      3'b100, 3'b101:  md_res_s = dvz_r ? {XLEN{1'b1}} : (neg_res_r ? (-quo_s) : quo_s);
      3'b110, 3'b111:  md_res_s = dvz_r ? dvd_r : (neg_rem_r ? (-rem_s) : rem_s);
      default:         md_res_s = {XLEN{1'b0}};
    endcase
    md_out_s = (state_r == ST_DONE) ? md_res_s : {XLEN{1'b0}};
    stall_s  = mop_s && (state_r != ST_DONE);
  end

  // Multiply/divide sequencer; flush discards any op in flight.
  always_ff @(posedge clock) begin
    if (reset || bus.flush) begin
      state_r   <= ST_IDLE;
      cnt_r     <= {CW{1'b0}};
      f3_r      <= 3'b000;
      opb_r     <= {XLEN{1'b0}};
      dvd_r     <= {XLEN{1'b0}};
      acc_r     <= {(2*XLEN){1'b0}};
      neg_res_r <= 1'b0;
      neg_rem_r <= 1'b0;
      dvz_r     <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (mop_s) begin
            f3_r      <= bus.func3;
            opb_r     <= b_mag_s;
            dvd_r     <= fwd1_s;
            acc_r     <= {{XLEN{1'b0}}, a_mag_s};
            neg_res_r <= a_sgn_s ^ b_sgn_s;
            neg_rem_r <= a_sgn_s;
            dvz_r     <= (fwd2_s == {XLEN{1'b0}});
            cnt_r     <= {CW{1'b0}};
            state_r   <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          acc_r <= acc_nxt_s;
          if (cnt_r == CW'(MULDIV_ITER - 1)) begin
            cnt_r   <= {CW{1'b0}};
            state_r <= ST_DONE;
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        ST_DONE: state_r <= ST_IDLE;
        default: state_r <= ST_IDLE;
      endcase
    end
  end
`else
  logic unused_ok_s;

  // No M unit: M-ops complete at once with a zero result.
  always_comb begin
    md_out_s = {XLEN{1'b0}};
    stall_s  = 1'b0;
  end

  assign unused_ok_s = ^{clock, reset, bus.flush, 32'(MULDIV_ITER)};
`endif

endmodule

// File: tb/tb_execute_stage.sv
// tb_execute_stage: directed vectors with hand-computed expectations for the
// EX stage. M-extension expectations follow RV32M_EN.
module tb_execute_stage;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks   = 0;
  int   failures = 0;

`ifdef RV32M_EN
  localparam bit M_EN = 1'b1;
`else
  localparam bit M_EN = 1'b0;
`endif

  execute_stage_if #(.XLEN(32)) bus ();

  execute_stage #(.XLEN(32), .MULDIV_ITER(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp_v);
    end
  endtask

  task automatic set_idle();
    bus.flush = 1'b0; bus.pc = 32'h0; bus.readData1 = 32'h0; bus.readData2 = 32'h0;
    bus.immediateValue = 32'h0; bus.func3 = 3'b000; bus.func7 = 7'b0000000;
    bus.aluSrc1 = 2'b00; bus.aluSrc2 = 2'b00; bus.aluOperation = 3'b000;
    bus.pcUpdate = 1'b0; bus.pcAdderSrc = 1'b0; bus.rs1 = 5'd0; bus.rs2 = 5'd0;
    bus.exMemRd = 5'd0; bus.memWbRd = 5'd0; bus.exMemRegWrite = 1'b0; bus.memWbRegWrite = 1'b0;
    bus.exMemData = 32'h0; bus.memWbData = 32'h0;
  endtask

  task automatic drive_r(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f3,
                         input logic [6:0] f7);
    set_idle();
    bus.rs1 = 5'd1; bus.rs2 = 5'd2; bus.readData1 = a; bus.readData2 = b;
    bus.aluOperation = 3'b010; bus.func3 = f3; bus.func7 = f7;
  endtask

  // Issue an M-op and hold it until it completes (or the bound expires).
  task automatic run_mop(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f3,
                         input logic [31:0] exp_v, input string tag, input bit scramble);
    int cycles;
    @(negedge clock);
    drive_r(a, b, f3, 7'b0000001);
    #2;
    cycles = 0;
    while (bus.stall && cycles < 200) begin
      cycles++;
      if (scramble && cycles == 5) begin
        bus.readData1 = 32'h1234_5678;
        bus.readData2 = 32'h0000_0003;
      end
      @(negedge clock);
      #2;
    end
    check({tag, "/stall_cycles"}, 32'(cycles), M_EN ? 32'd33 : 32'd0);
    check(tag, bus.aluResult, M_EN ? exp_v : 32'h0);
    check({tag, "/taken"}, {31'd0, bus.branchTaken}, 32'd0);
    set_idle();
  endtask

  // Abort an in-flight divide with flush (kind 0) or reset (kind 1).
  task automatic abort_case(input bit use_reset, input string tag);
    @(negedge clock);
    drive_r(32'd100, 32'd7, 3'b101, 7'b0000001);
    repeat (10) @(negedge clock);
    #2;
    check({tag, "/busy_stall"}, {31'd0, bus.stall}, M_EN ? 32'd1 : 32'd0);
    if (use_reset) reset = 1'b1;
    else           bus.flush = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    drive_r(32'd5, 32'd7, 3'b000, 7'b0000000);
    #2;
    check({tag, "/stall_after"}, {31'd0, bus.stall}, 32'd0);
    check({tag, "/add_after"}, bus.aluResult, 32'd12);
    set_idle();
    run_mop(32'd100, 32'd7, 3'b101, 32'd14, {tag, "/divu_after"}, 1'b0);
  endtask

  initial begin
    set_idle();
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    #2;
    check("rst/aluResult", bus.aluResult, 32'h0);
    check("rst/storeData", bus.storeData, 32'h0);
    check("rst/taken", {31'd0, bus.branchTaken}, 32'd0);
    check("rst/target", bus.branchTarget, 32'h0);
    check("rst/stall", {31'd0, bus.stall}, 32'd0);

    // R/I-type ALU
    @(negedge clock); drive_r(32'd5, 32'd7, 3'b000, 7'b0000000); #2;
    check("add", bus.aluResult, 32'd12);
    check("add/stall", {31'd0, bus.stall}, 32'd0);
    drive_r(32'd5, 32'd7, 3'b000, 7'b0100000); #1;
    check("sub", bus.aluResult, 32'hFFFF_FFFE);
    drive_r(32'd5, 32'd0, 3'b000, 7'b0100000);
    bus.aluOperation = 3'b011; bus.aluSrc2 = 2'b01; bus.immediateValue = 32'h0000_0400; #1;
    check("addi_ignores_f7", bus.aluResult, 32'h0000_0405);
    drive_r(32'h8000_0000, 32'd0, 3'b101, 7'b0100000);
    bus.aluOperation = 3'b011; bus.aluSrc2 = 2'b01; bus.immediateValue = 32'h0000_0404; #1;
    check("srai", bus.aluResult, 32'hF800_0000);
    drive_r(32'h8000_0000, 32'd4, 3'b101, 7'b0000000); #1;
    check("srl", bus.aluResult, 32'h0800_0000);
    drive_r(32'hFFFF_FFFF, 32'd1, 3'b010, 7'b0000000); #1;
    check("slt", bus.aluResult, 32'd1);
    drive_r(32'hFFFF_FFFF, 32'd1, 3'b011, 7'b0000000); #1;
    check("sltu", bus.aluResult, 32'd0);

    // forwarding priority
    set_idle();
    bus.rs1 = 5'd3; bus.rs2 = 5'd3; bus.readData1 = 32'h11; bus.readData2 = 32'h22;
    bus.exMemRd = 5'd3; bus.exMemData = 32'hAA; bus.exMemRegWrite = 1'b1;
    bus.memWbRd = 5'd3; bus.memWbData = 32'hBB; bus.memWbRegWrite = 1'b1; #1;
    check("fwd/mem_first", bus.aluResult, 32'h154);
    check("fwd/store", bus.storeData, 32'hAA);
    bus.exMemRd = 5'd0; #1;
    check("fwd/wb_when_rd0", bus.storeData, 32'hBB);
    bus.exMemRd = 5'd3; bus.exMemRegWrite = 1'b0; #1;
    check("fwd/wb_when_nowe", bus.storeData, 32'hBB);
    bus.memWbRegWrite = 1'b0; #1;
    check("fwd/regfile", bus.storeData, 32'h22);

    // branches and jumps
    drive_r(32'hFFFF_FFFF, 32'd1, 3'b100, 7'b0000000);
    bus.aluOperation = 3'b001; bus.pcUpdate = 1'b1; bus.pc = 32'h100; bus.immediateValue = 32'h20; #1;
    check("blt/taken", {31'd0, bus.branchTaken}, 32'd1);
    check("blt/target", bus.branchTarget, 32'h120);
    check("blt/result", bus.aluResult, 32'h0);
    bus.func3 = 3'b110; #1;
    check("bltu/taken", {31'd0, bus.branchTaken}, 32'd0);
    bus.func3 = 3'b001; #1;
    check("bne/taken", {31'd0, bus.branchTaken}, 32'd1);
    set_idle();
    bus.rs1 = 5'd4; bus.readData1 = 32'h1001; bus.pc = 32'h200; bus.immediateValue = 32'h10;
    bus.pcUpdate = 1'b1; bus.pcAdderSrc = 1'b1; bus.aluSrc1 = 2'b01; bus.aluSrc2 = 2'b10; #1;
    check("jalr/taken", {31'd0, bus.branchTaken}, 32'd1);
    check("jalr/target", bus.branchTarget, 32'h1010);
    check("jalr/link", bus.aluResult, 32'h204);
    set_idle();
    bus.aluOperation = 3'b100; bus.immediateValue = 32'h1234_5000; #1;
    check("lui", bus.aluResult, 32'h1234_5000);
    set_idle();

    // M extension
    run_mop(32'hFFFF_FFFF, 32'd2, 3'b000, 32'hFFFF_FFFE, "mul", 1'b0);
    run_mop(32'hFFFF_FFFF, 32'd2, 3'b001, 32'hFFFF_FFFF, "mulh", 1'b0);
    run_mop(32'hFFFF_FFFF, 32'd2, 3'b011, 32'h0000_0001, "mulhu", 1'b0);
    run_mop(32'hFFFF_FFFF, 32'd2, 3'b010, 32'hFFFF_FFFF, "mulhsu", 1'b0);
    run_mop(32'd7, 32'd0, 3'b100, 32'hFFFF_FFFF, "div_by0", 1'b0);
    run_mop(32'd7, 32'd0, 3'b110, 32'd7, "rem_by0", 1'b0);
    run_mop(32'h8000_0000, 32'hFFFF_FFFF, 3'b100, 32'h8000_0000, "div_ovf", 1'b0);
    run_mop(32'h8000_0000, 32'hFFFF_FFFF, 3'b110, 32'h0, "rem_ovf", 1'b0);
    run_mop(32'd100, 32'd7, 3'b101, 32'd14, "divu", 1'b0);
    run_mop(32'd100, 32'd7, 3'b111, 32'd2, "remu", 1'b0);
    run_mop(32'hFFFF_FFF9, 32'd2, 3'b100, 32'hFFFF_FFFD, "div_neg", 1'b0);
    run_mop(32'hFFFF_FFF9, 32'd2, 3'b110, 32'hFFFF_FFFF, "rem_neg", 1'b0);
    run_mop(32'd6, 32'd7, 3'b000, 32'd42, "mul_latched", 1'b1);

    // aborts
    abort_case(1'b0, "flush");
    abort_case(1'b1, "reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
